// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV64I multicycle control unit and its datapath.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Instruction classes resolved in DECODE and latched for EXEC/MEM/WB.
  typedef enum logic [2:0] {
    C_ADD  = 3'd0,
    C_SUB  = 3'd1,
    C_ADDI = 3'd2,
    C_LD   = 3'd3,
    C_SD   = 3'd4,
    C_BEQ  = 3'd5,
    C_BNE  = 3'd6,
    C_LUI  = 3'd7
  } iclass_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_IMM = 2'b10;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_ILL  = 2'b01;
  localparam logic [1:0] HC_TMO  = 2'b10;

endpackage

// File: rtl/decod_opcode.sv
// Combinational opcode classifier: major opcode + funct3 + funct7[5] -> class/illegal.
module decod_opcode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output iclass_t    iclass,
  output logic       illegal
);

  // Map each supported opcode to its class; anything else is illegal.
  always_comb begin
    iclass  = C_ADD;
    illegal = 1'b0;
    case (op)
      OP_R:   iclass = funct7_b5 ? C_SUB : C_ADD;
      OP_IMM: iclass = C_ADDI;
      OP_LD:  iclass = C_LD;
      OP_SD:  iclass = C_SD;
      OP_LUI: iclass = C_LUI;
      OP_BR: begin
        if (funct3 == 3'b000)      iclass = C_BEQ;
        else if (funct3 == 3'b001) iclass = C_BNE;
        else                       illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle FSM control unit: FETCH/DECODE/EXEC/MEM/WB with memory-wait timeout.
module unidade_controle
  import cpu_ctrl_pkg::*;
#(
  parameter int WAIT_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PC_Write,
  output logic        PC_Src,
  output logic        IR_Write,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Reg_Write,
  output logic        ALU_SrcA,
  output logic [1:0]  ALU_SrcB,
  output logic [2:0]  ALU_Op,
  output logic [1:0]  MemToReg,
  output logic [2:0]  STT,
  output logic [1:0]  halt_cause
);

  // Last stalled count before timeout: the (2^WAIT_W-1)-th stall halts.
  localparam logic [WAIT_W-1:0] TMO_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  state_t            state, state_nxt;
  iclass_t           cls, dec_cls;
  logic              dec_ill;
  logic              armed;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic [1:0]        cause_nxt;
  logic              stall, tmo;

  // Only opcode, funct3 and bit 30 matter to control.
  logic unused_ir;
  assign unused_ir = ^{opcode[31], opcode[29:15], opcode[11:7]};

  decod_opcode u_dec (
    .op        (opcode[6:0]),
    .funct3    (opcode[14:12]),
    .funct7_b5 (opcode[30]),
    .iclass    (dec_cls),
    .illegal   (dec_ill)
  );

  assign STT = state;

  // State, class latch, wait counter and sticky halt cause. armed delays
  // leaving RST by one edge so the first FETCH is the second edge after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_RST;
      cls        <= C_ADD;
      armed      <= 1'b0;
      cnt        <= '0;
      halt_cause <= HC_NONE;
    end else begin
      state      <= state_nxt;
      armed      <= 1'b1;
      cnt        <= cnt_nxt;
      halt_cause <= cause_nxt;
      if (state == S_DECODE) cls <= dec_cls;
    end
  end

  // Next-state, timeout detection and wait-counter update.
  always_comb begin
    state_nxt = state;
    cause_nxt = halt_cause;
    stall     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    tmo       = stall && (cnt == TMO_LAST);
    case (state)
      S_RST:    if (armed) state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_nxt = S_DECODE;
        else if (tmo) begin
          state_nxt = S_HALT;
          cause_nxt = HC_TMO;
        end
      end
      S_DECODE: begin
        if (dec_ill) begin
          state_nxt = S_HALT;
          cause_nxt = HC_ILL;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LD, C_SD:   state_nxt = S_MEM;
          C_BEQ, C_BNE: state_nxt = S_FETCH;
          default:      state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) state_nxt = (cls == C_LD) ? S_WB : S_FETCH;
        else if (tmo) begin
          state_nxt = S_HALT;
          cause_nxt = HC_TMO;
        end
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RST;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    else if (stall)         cnt_nxt = cnt + WAIT_W'(1);
    else                    cnt_nxt = cnt;
  end

  // Moore strobe decode; only the FETCH completion strobes look at mem_ready.
  always_comb begin
    PC_Write  = 1'b0;
    PC_Src    = 1'b0;
    IR_Write  = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    Reg_Write = 1'b0;
    ALU_SrcA  = 1'b0;
    ALU_SrcB  = SRCB_B;
    ALU_Op    = 3'b000;
    MemToReg  = M2R_ALU;
    case (state)
      S_FETCH: begin
        Mem_Read = 1'b1;
        ALU_SrcB = SRCB_4;
        ALU_Op   = ALU_ADD;
        IR_Write = mem_ready;
        PC_Write = mem_ready;
      end
      S_EXEC: begin
        case (cls)
          C_ADD: begin
            ALU_SrcA = 1'b1;
            ALU_Op   = ALU_ADD;
          end
          C_SUB: begin
            ALU_SrcA = 1'b1;
            ALU_Op   = ALU_SUB;
          end
          C_ADDI, C_LD, C_SD: begin
            ALU_SrcA = 1'b1;
            ALU_SrcB = SRCB_IMM;
            ALU_Op   = ALU_ADD;
          end
          C_LUI: begin
            ALU_SrcB = SRCB_IMM;
            ALU_Op   = ALU_PASSB;
          end
          default: begin
            ALU_SrcA = 1'b1;
            ALU_Op   = ALU_SUB;
            PC_Src   = 1'b1;
            PC_Write = (cls == C_BEQ) ? zero : !zero;
          end
        endcase
      end
      S_MEM: begin
        Mem_Read  = (cls == C_LD);
        Mem_Write = (cls == C_SD);
      end
      S_WB: begin
        Reg_Write = 1'b1;
        MemToReg  = (cls == C_LD) ? M2R_MDR : (cls == C_LUI) ? M2R_IMM : M2R_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench: per-instruction expected cycle traces built from the ISA rules.
module tb_unidade_controle;

  localparam int WAIT_W = 4;
  localparam int TMO    = (1 << WAIT_W) - 1;

  localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LD = 3, K_SD = 4,
                 K_BEQ = 5, K_BNE = 6, K_LUI = 7, K_ILL = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] opcode = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PC_Write, PC_Src, IR_Write, Mem_Read, Mem_Write, Reg_Write, ALU_SrcA;
  logic [1:0]  ALU_SrcB, MemToReg, halt_cause;
  logic [2:0]  ALU_Op, STT;

  unidade_controle #(.WAIT_W(WAIT_W)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PC_Write(PC_Write), .PC_Src(PC_Src), .IR_Write(IR_Write), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Reg_Write(Reg_Write), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB),
    .ALU_Op(ALU_Op), .MemToReg(MemToReg), .STT(STT), .halt_cause(halt_cause)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] stt;
    logic       pcw, pcs, irw, mr, mw, rw, sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic [1:0] m2r;
    logic [1:0] hc;
  } exp_t;

  exp_t q_exp[$];
  bit   q_rdy[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t blank(input int s);
    exp_t e;
    e = '0;
    e.stt = 3'(s);
    return e;
  endfunction

  function automatic exp_t obs_now();
    exp_t o;
    o.stt = STT; o.pcw = PC_Write; o.pcs = PC_Src; o.irw = IR_Write;
    o.mr = Mem_Read; o.mw = Mem_Write; o.rw = Reg_Write; o.sa = ALU_SrcA;
    o.sb = ALU_SrcB; o.op = ALU_Op; o.m2r = MemToReg; o.hc = halt_cause;
    return o;
  endfunction

  function automatic int classify(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return ins[30] ? K_SUB : K_ADD;
      7'b0010011: return K_ADDI;
      7'b0000011: return K_LD;
      7'b0100011: return K_SD;
      7'b0110111: return K_LUI;
      7'b1100011: return (ins[14:12] == 3'd0) ? K_BEQ : (ins[14:12] == 3'd1) ? K_BNE : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  task automatic step(input bit r);
    @(negedge clock);
    mem_ready = r;
    #1;
  endtask

  task automatic push(input exp_t e, input bit r);
    q_exp.push_back(e);
    q_rdy.push_back(r);
  endtask

  task automatic push_halt(input logic [1:0] hc, input int n);
    exp_t e;
    e = blank(6);
    e.hc = hc;
    for (int i = 0; i < n; i++) push(e, 1'($urandom_range(0, 1)));
  endtask

  // w stalled cycles then a ready cycle; a wait of TMO or more halts instead.
  task automatic push_wait(input exp_t base, input exp_t done, input int w, output bit to);
    to = 1'b0;
    for (int k = 0; k < w && k < TMO; k++) push(base, 1'b0);
    if (w >= TMO) begin
      to = 1'b1;
      push_halt(2'b10, 4);
    end else begin
      push(done, 1'b1);
    end
  endtask

  // Expected per-cycle trace of one instruction starting in FETCH.
  task automatic model(input logic [31:0] ins, input bit z, input int wf, input int wm);
    exp_t f, fr, e;
    bit   to;
    int   k;
    f = blank(1); f.mr = 1; f.sb = 2'b01; f.op = 3'b001;
    fr = f; fr.irw = 1; fr.pcw = 1;
    push_wait(f, fr, wf, to);
    if (to) return;
    push(blank(2), 1'($urandom_range(0, 1)));
    k = classify(ins);
    if (k == K_ILL) begin
      push_halt(2'b01, 4);
      return;
    end
    e = blank(3);
    case (k)
      K_ADD:  begin e.sa = 1; e.op = 3'b001; end
      K_SUB:  begin e.sa = 1; e.op = 3'b010; end
      K_LUI:  begin e.sb = 2'b10; e.op = 3'b011; end
      K_BEQ, K_BNE: begin
        e.sa = 1; e.op = 3'b010; e.pcs = 1;
        e.pcw = (k == K_BEQ) ? z : !z;
      end
      default: begin e.sa = 1; e.sb = 2'b10; e.op = 3'b001; end
    endcase
    push(e, 1'($urandom_range(0, 1)));
    if (k == K_BEQ || k == K_BNE) return;
    if (k == K_LD || k == K_SD) begin
      e = blank(4);
      if (k == K_LD) e.mr = 1; else e.mw = 1;
      push_wait(e, e, wm, to);
      if (to || k == K_SD) return;
    end
    e = blank(5);
    e.rw = 1;
    e.m2r = (k == K_LD) ? 2'b01 : (k == K_LUI) ? 2'b10 : 2'b00;
    push(e, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    opcode = 32'h00500093;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      tests++;
      if (obs_now() !== blank(0)) begin
        fails++; $display("FAIL reset_hold: got %h expected %h", obs_now(), blank(0));
      end
    end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #1;
    tests++;
    if (STT !== 3'd0) begin fails++; $display("FAIL reset_first_edge: STT got %0d expected 0", STT); end
    model(opcode, 1'b0, 0, 0);
    while (q_exp.size() > 0) begin
      exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
      if (obs_now() !== e) begin fails++; $display("FAIL reset_release: got %h expected %h", obs_now(), e); end
    end
  endtask

  task automatic test_addi();
    opcode = 32'h00500093;
    model(opcode, 1'b0, 0, 0);
    while (q_exp.size() > 0) begin
      exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
      if (obs_now() !== e) begin fails++; $display("FAIL addi: got %h expected %h", obs_now(), e); end
    end
  endtask

  task automatic test_ld_sd();
    logic [31:0] ins [2];
    ins[0] = 32'h00003083;
    ins[1] = 32'h00113023;
    for (int j = 0; j < 2; j++) begin
      opcode = ins[j];
      model(opcode, 1'b0, 1, 3);
      while (q_exp.size() > 0) begin
        exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
        if (obs_now() !== e) begin fails++; $display("FAIL ld_sd[%0d]: got %h expected %h", j, obs_now(), e); end
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [4];
    ins[0] = 32'h00000063; ins[1] = 32'h00001063;
    ins[2] = 32'h00208063; ins[3] = 32'h00209063;
    for (int j = 0; j < 4; j++) begin
      opcode = ins[j];
      zero = (j < 2);
      model(opcode, zero, 0, 0);
      while (q_exp.size() > 0) begin
        exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
        if (obs_now() !== e) begin fails++; $display("FAIL branch[%0d]: got %h expected %h", j, obs_now(), e); end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: begin ins[6:0] = 7'b0110011; ins[30] = 1'b0; end
        1: begin ins[6:0] = 7'b0110011; ins[30] = 1'b1; end
        2: ins[6:0] = 7'b0010011;
        3: ins[6:0] = 7'b0000011;
        4: ins[6:0] = 7'b0100011;
        5: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'd0; end
        6: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'd1; end
        default: ins[6:0] = 7'b0110111;
      endcase
      opcode = ins;
      zero = 1'($urandom_range(0, 1));
      model(ins, zero, $urandom_range(0, 4), $urandom_range(0, 4));
      while (q_exp.size() > 0) begin
        exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
        if (obs_now() !== e) begin fails++; $display("FAIL random[%0d] ins=%h: got %h expected %h", n, ins, obs_now(), e); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    for (int n = 0; n < 9; n++) begin
      if (n == 0) ins = 32'h0000007F;
      else begin
        ins = $urandom;
        if (n[0]) begin ins[6:0] = 7'b1100011; ins[14:12] = 3'($urandom_range(2, 7)); end
        else begin
          for (int t = 0; t < 64 && classify(ins) != K_ILL; t++) ins[6:0] = 7'($urandom);
          if (classify(ins) != K_ILL) ins[6:0] = 7'h7F;
        end
      end
      do_reset();
      opcode = ins;
      model(ins, 1'b0, $urandom_range(0, 2), 0);
      if (n == 0) push_halt(2'b01, 16);
      while (q_exp.size() > 0) begin
        exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
        if (obs_now() !== e) begin fails++; $display("FAIL illegal[%0d] ins=%h: got %h expected %h", n, ins, obs_now(), e); end
      end
    end
    do_reset();
    opcode = 32'h00500093;
    model(opcode, 1'b0, 0, 0);
    while (q_exp.size() > 0) begin
      exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
      if (obs_now() !== e) begin fails++; $display("FAIL illegal_recover: got %h expected %h", obs_now(), e); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] ins [2];
    int wf [2], wm [2];
    ins[0] = 32'h00500093; wf[0] = 20; wm[0] = 0;
    ins[1] = 32'h00003083; wf[1] = 0;  wm[1] = 20;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      opcode = ins[j];
      model(opcode, 1'b0, wf[j], wm[j]);
      while (q_exp.size() > 0) begin
        exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
        if (obs_now() !== e) begin fails++; $display("FAIL timeout[%0d]: got %h expected %h", j, obs_now(), e); end
      end
    end
  endtask

  task automatic test_reset_mid_sd();
    do_reset();
    opcode = 32'h00113023;
    model(opcode, 1'b0, 0, 10);
    for (int i = 0; i < 5; i++) begin
      exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
      if (obs_now() !== e) begin fails++; $display("FAIL sd_pre_reset: got %h expected %h", obs_now(), e); end
    end
    q_exp.delete();
    q_rdy.delete();
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    tests++;
    if (obs_now() !== blank(0)) begin fails++; $display("FAIL sd_async_reset: got %h expected %h", obs_now(), blank(0)); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    model(opcode, 1'b0, 0, 0);
    while (q_exp.size() > 0) begin
      exp_t e; e = q_exp.pop_front(); step(q_rdy.pop_front()); tests++;
      if (obs_now() !== e) begin fails++; $display("FAIL sd_recover: got %h expected %h", obs_now(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ld_sd();
    test_branch();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_mid_sd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
